// File: rtl/issue_ctrl.sv
// issue_ctrl: one-entry issue register with a load scoreboard, hazard stall,
// flush handling and an illegal-instruction trap handshake.
module issue_ctrl #(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_dec_valid,
    output logic        o_dec_stall,
    input  logic [31:0] i_dec_pc,
    input  logic [4:0]  i_dec_rs1,
    input  logic [4:0]  i_dec_rs2,
    input  logic [4:0]  i_dec_rd,
    input  logic        i_dec_use_rs1,
    input  logic        i_dec_use_rs2,
    input  logic        i_dec_wr_rd,
    input  logic        i_dec_long,
    input  logic        i_dec_illegal,
    output logic        o_iss_valid,
    input  logic        i_iss_ready,
    output logic [31:0] o_iss_pc,
    output logic [4:0]  o_iss_rd,
    output logic        o_iss_long,
    input  logic        i_wb_valid,
    input  logic [4:0]  i_wb_rd,
    input  logic        i_flush,
    output logic        o_trap,
    output logic [31:0] o_trap_pc,
    input  logic        i_trap_ack,
    output logic        o_err
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW:0] MAX_W = (CW + 1)'(MAX_OUTSTANDING);
    typedef enum logic {RUN, TRAP} state_t;
    state_t        state_q;
    logic [31:0]   busy_q, busy_d, wb_mask, held_mask, blk;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW:0]   pend;
    logic          iss_valid_q, iss_long_q, err_q;
    logic [31:0]   iss_pc_q, trap_pc_q;
    logic [4:0]    iss_rd_q;
    logic          hazard, full, accept, hs, inc, err_set;
    always_comb begin
        wb_mask     = i_wb_valid ? 32'd1 << i_wb_rd : 32'd0;
        held_mask   = (iss_valid_q & iss_long_q) ? 32'd1 << iss_rd_q : 32'd0;
        // x0 never blocks: it is neither tracked nor written
        blk         = ((busy_q & ~wb_mask) | held_mask) & 32'hFFFF_FFFE;
        hazard      = (i_dec_use_rs1 & blk[i_dec_rs1]) | (i_dec_use_rs2 & blk[i_dec_rs2])
                    | (i_dec_wr_rd & blk[i_dec_rd]);
        pend        = {1'b0, cnt_q} + {{CW{1'b0}}, iss_valid_q & iss_long_q};
        full        = i_dec_long & (pend >= MAX_W) & ~i_wb_valid;
        o_dec_stall = (state_q == TRAP) | (i_dec_valid & (hazard | full)) | (iss_valid_q & ~i_iss_ready);
        accept      = (state_q == RUN) & i_dec_valid & ~o_dec_stall & ~i_flush;
        hs          = iss_valid_q & i_iss_ready & ~i_flush;
        inc         = hs & iss_long_q;
        busy_d      = ((busy_q & ~wb_mask) | (inc ? 32'd1 << iss_rd_q : 32'd0)) & 32'hFFFF_FFFE;
        err_set     = i_wb_valid & ~inc & (cnt_q == '0);
        cnt_d       = (inc & ~i_wb_valid) ? cnt_q + CW'(1) :
                      (~inc & i_wb_valid & cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    end
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= RUN;
            busy_q      <= '0;
            cnt_q       <= '0;
            iss_valid_q <= 1'b0;
            iss_pc_q    <= '0;
            iss_rd_q    <= '0;
            iss_long_q  <= 1'b0;
            trap_pc_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            if (err_set) err_q <= 1'b1;
            if (i_flush) begin
                iss_valid_q <= 1'b0;
            end else if (accept & ~i_dec_illegal) begin
                iss_valid_q <= 1'b1;
                iss_pc_q    <= i_dec_pc;
                iss_rd_q    <= i_dec_rd;
                iss_long_q  <= i_dec_long;
            end else if (hs) begin
                iss_valid_q <= 1'b0;
            end
            if (state_q == TRAP && i_trap_ack) begin
                state_q <= RUN;
            end else if (accept & i_dec_illegal) begin
                state_q   <= TRAP;
                trap_pc_q <= i_dec_pc;
            end
        end
    end
    assign o_iss_valid = iss_valid_q;
    assign o_iss_pc    = iss_pc_q;
    assign o_iss_rd    = iss_rd_q;
    assign o_iss_long  = iss_long_q;
    assign o_trap      = (state_q == TRAP);
    assign o_trap_pc   = trap_pc_q;
    assign o_err       = err_q;
endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl: directed scenarios plus random traffic against a behavioural
// model of the issue stage (outstanding-load table, trap flag, error flag).
module tb_issue_ctrl;
    localparam int MAX = 2;
    logic        clk = 1'b0, rst = 1'b1;
    logic        dv, stall, use1, use2, wr, dlong, ill, iv, ready, ilong, wbv, flush, trap, ack, err;
    logic [31:0] pc, ipc, tpc;
    logic [4:0]  rs1, rs2, rd, ird, wbrd;
    int          checks = 0, errors = 0;
    bit          mv, mlong, mtrap, merr;
    bit          mbusy[32];
    logic [31:0] mpc, mtpc;
    logic [4:0]  mrd;
    int          mcnt;

    issue_ctrl #(.MAX_OUTSTANDING(MAX)) dut (
        .i_clk(clk), .i_reset(rst), .i_dec_valid(dv), .o_dec_stall(stall), .i_dec_pc(pc),
        .i_dec_rs1(rs1), .i_dec_rs2(rs2), .i_dec_rd(rd), .i_dec_use_rs1(use1),
        .i_dec_use_rs2(use2), .i_dec_wr_rd(wr), .i_dec_long(dlong), .i_dec_illegal(ill),
        .o_iss_valid(iv), .i_iss_ready(ready), .o_iss_pc(ipc), .o_iss_rd(ird),
        .o_iss_long(ilong), .i_wb_valid(wbv), .i_wb_rd(wbrd), .i_flush(flush),
        .o_trap(trap), .o_trap_pc(tpc), .i_trap_ack(ack), .o_err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // A register blocks if a load to it is still in flight and not waking now,
    // or if the load targeting it is sitting in the issue register.
    function automatic bit blocked(input logic [4:0] r);
        if (r == 0) return 0;
        return (mbusy[r] && !(wbv && wbrd == r)) || (mv && mlong && mrd == r);
    endfunction

    task automatic model_reset();
        mv = 0; mlong = 0; mtrap = 0; merr = 0; mpc = 0; mtpc = 0; mrd = 0; mcnt = 0;
        foreach (mbusy[i]) mbusy[i] = 0;
    endtask

    // Called at a negedge with inputs applied; checks, advances the model, runs one clock.
    task automatic step();
        bit exp_stall, acc, hs, inc, full, haz;
        #1;
        chk("iss_valid", iv, mv);
        chk("iss_pc", ipc, mpc);
        chk("iss_rd", ird, mrd);
        chk("iss_long", ilong, mlong);
        chk("trap", trap, mtrap);
        chk("trap_pc", tpc, mtpc);
        chk("err", err, merr);
        haz = (use1 && blocked(rs1)) || (use2 && blocked(rs2)) || (wr && blocked(rd));
        full = dlong && (mcnt + ((mv && mlong) ? 1 : 0)) >= MAX && !wbv;
        exp_stall = mtrap || (dv && (haz || full)) || (mv && !ready);
        if (dv) chk("dec_stall", stall, exp_stall);
        if (rst) model_reset();
        else begin
            hs  = mv && ready && !flush;
            acc = !mtrap && dv && !exp_stall && !flush;
            inc = hs && mlong;
            if (wbv) mbusy[wbrd] = 0;
            if (inc && mrd != 0) mbusy[mrd] = 1;
            if (inc && !wbv) mcnt++;
            else if (!inc && wbv) begin
                if (mcnt == 0) merr = 1;
                else mcnt--;
            end
            if (mtrap) begin
                if (ack) mtrap = 0;
            end else if (acc && ill) begin
                mtrap = 1;
                mtpc = pc;
            end
            if (flush) mv = 0;
            else if (acc && !ill) begin
                mv = 1; mpc = pc; mrd = rd; mlong = dlong;
            end else if (hs) mv = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clr();
        dv = 0; pc = 0; rs1 = 0; rs2 = 0; rd = 0; use1 = 0; use2 = 0; wr = 0; dlong = 0; ill = 0;
        ready = 1; wbv = 0; wbrd = 0; flush = 0; ack = 0;
    endtask

    task automatic ins(input logic [31:0] p, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input bit u1, input bit u2, input bit w,
                       input bit l, input bit il);
        dv = 1; pc = p; rs1 = a; rs2 = b; rd = d; use1 = u1; use2 = u2; wr = w; dlong = l; ill = il;
    endtask

    initial begin
        model_reset();
        clr();
        rst = 1;
        @(negedge clk);
        step(); step();
        rst = 0;
        // back-to-back ALU ops
        ins(32'h10, 0, 0, 1, 0, 0, 1, 0, 0); step();
        ins(32'h14, 1, 0, 2, 1, 0, 1, 0, 0); step();
        chk("alu_pc", ipc, 32'h14);
        clr(); step();
        // load x5 then dependent add, woken by same-cycle writeback
        ins(32'h20, 0, 0, 5, 0, 0, 1, 1, 0); step();
        ins(32'h24, 5, 1, 6, 1, 1, 1, 0, 0); step(); step();
        wbv = 1; wbrd = 5; step();
        clr();
        chk("raw_pc", ipc, 32'h24);
        step();
        // three loads against an outstanding limit of two
        ins(32'h30, 0, 0, 1, 0, 0, 1, 1, 0); step();
        ins(32'h34, 0, 0, 2, 0, 0, 1, 1, 0); step();
        ins(32'h38, 0, 0, 3, 0, 0, 1, 1, 0); step(); step();
        wbv = 1; wbrd = 1; step();
        clr(); wbv = 1; wbrd = 2; step();
        wbv = 1; wbrd = 3; step();
        clr(); step();
        // flush of a held load leaves no scoreboard trace
        ins(32'h40, 0, 0, 7, 0, 0, 1, 1, 0); step();
        clr(); ready = 0; step();
        flush = 1; step();
        clr();
        chk("flush_valid", iv, 0);
        ins(32'h44, 7, 0, 8, 1, 0, 1, 0, 0);
        #1 chk("flush_nostall", stall, 0);
        step();
        clr(); step();
        // illegal instruction trap
        ins(32'h100, 0, 0, 0, 0, 0, 0, 0, 1); step();
        ins(32'h104, 0, 0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step();
        chk("trap_pc_100", tpc, 32'h100);
        ack = 1; step();
        ack = 0; step();
        clr(); step();
        // spurious writeback sets sticky error, reset clears everything
        wbv = 1; wbrd = 9; step();
        clr(); step(); step();
        chk("err_sticky", err, 1);
        rst = 1; step();
        rst = 0; step();
        chk("rst_err", err, 0);
        // random traffic
        for (int n = 0; n < 4000; n++) begin
            clr();
            rst   = ($urandom % 300) == 0;
            dv    = ($urandom % 4) != 0;
            pc    = $urandom & 32'hFFFF_FFFC;
            rs1   = 5'($urandom % 8);
            rs2   = 5'($urandom % 8);
            rd    = 5'($urandom % 8);
            use1  = $urandom % 2;
            use2  = $urandom % 2;
            dlong = ($urandom % 3) == 0;
            wr    = dlong ? 1'b1 : 1'($urandom % 2);
            ill   = ($urandom % 30) == 0;
            ready = ($urandom % 10) < 7;
            flush = ($urandom % 20) == 0;
            ack   = ($urandom % 4) == 0;
            if (mcnt > 0 && ($urandom % 2) == 1) begin
                wbv = 1;
                wbrd = 5'($urandom % 8);
                for (int t = 0; t < 8 && !mbusy[wbrd]; t++) wbrd = 5'($urandom % 8);
            end else if (($urandom % 60) == 0) begin
                wbv = 1;
                wbrd = 5'($urandom % 32);
            end
            step();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_ctrl.md
Name: issue_ctrl

Overview:
Issue-stage controller between the instruction decoder and the execute stage of the RISC-V core. It owns a one-entry issue register and a 32-bit register scoreboard for long-latency ops (loads), and it stalls decode on RAW/WAW hazards or when too many long ops are outstanding. It also drops the held instruction on a branch flush and sequences an illegal-instruction trap handshake.

Parameters:
MAX_OUTSTANDING, 2, max long ops issued but not yet written back (1..7); the counter is $clog2(MAX_OUTSTANDING+1) bits wide.

Ports:
i_clk  input  1  clock, all state updates on rising edge
i_reset  input  1  synchronous active-high reset
i_dec_valid  input  1  decoder presents an instruction
o_dec_stall  output  1  decoder must hold (drives decoder i_stalled); combinational
i_dec_pc  input  32  instruction PC
i_dec_rs1, i_dec_rs2, i_dec_rd  input  5 each  register indices
i_dec_use_rs1, i_dec_use_rs2, i_dec_wr_rd  input  1 each  operand/destination usage
i_dec_long  input  1  long-latency op (load); result arrives via writeback port
i_dec_illegal  input  1  instruction is illegal
o_iss_valid  output  1  issue register holds an instruction
i_iss_ready  input  1  execute accepts it this cycle
o_iss_pc  output  32  held PC
o_iss_rd  output  5  held destination
o_iss_long  output  1  held op is long
i_wb_valid  input  1  a long op completes
i_wb_rd  input  5  its destination
i_flush  input  1  branch redirect: drop the held and presented instruction
o_trap  output  1  illegal-instruction trap pending
o_trap_pc  output  32  PC of the trapping instruction
i_trap_ack  input  1  trap handler taken
o_err  output  1  sticky: writeback seen with zero outstanding

Behaviour:
- Reset: o_iss_valid=0, o_iss_pc=0, o_iss_rd=0, o_iss_long=0, busy[31:0]=0, count=0, state=RUN, o_trap=0, o_trap_pc=0, o_err=0. Reset mid-trap or mid-load discards everything, and late writebacks do not set o_err until count would underflow again.
- States: RUN, TRAP. RUN→TRAP when an illegal instruction is accepted. TRAP→RUN on i_trap_ack. In TRAP, o_dec_stall=1 and o_trap=1; i_flush still clears the issue register.
- Effective busy: busyx[r] = busy[r] & ~(i_wb_valid & i_wb_rd==r). Same-cycle writeback wakes the dependant. busyx[0] is always 0.
- Issue-register conflict: ic = o_iss_valid & o_iss_long & o_iss_rd!=0 & o_iss_rd==r.
- hazard = (use_rs1 & (busyx[rs1] | ic(rs1))) | (use_rs2 & (busyx[rs2] | ic(rs2))) | (wr_rd & (busyx[rd] | ic(rd))).
- full = i_dec_long & (count + (o_iss_valid&o_iss_long)) >= MAX_OUTSTANDING & ~i_wb_valid.
- o_dec_stall = TRAP | (i_dec_valid & (hazard | full)) | (o_iss_valid & ~i_iss_ready). o_dec_stall is don't-care when i_dec_valid=0.
- accept = RUN & i_dec_valid & ~o_dec_stall & ~i_flush.
  - Accept of a legal instruction loads the issue register; o_iss_valid rises next cycle (latency 1).
  - Accept of an illegal instruction leaves the issue register empty, latches o_trap_pc and enters TRAP.
- Issue handshake (o_iss_valid & i_iss_ready): the register empties unless refilled the same cycle. If o_iss_long, then busy[o_iss_rd] is set (unless rd=0) and count increments.
- Writeback clears busy[i_wb_rd] and decrements count.
  - Simultaneous inc and dec leaves count unchanged.
  - A writeback with count==0 and no increment leaves count at 0 and sets o_err.
- i_flush: o_iss_valid←0 next cycle, with no busy or count update for the dropped op. An issue handshake in the same cycle as i_flush is ignored. Outstanding busy bits and count persist. Priority: reset > flush > handshake/accept.
- While o_iss_valid & ~i_iss_ready, all o_iss_* outputs hold stable.

Test Plan:
- Back-to-back ALU ops (x1←, x2←, no long ops), i_iss_ready=1: one issue per cycle, o_dec_stall=0, each o_iss_pc equals the accepted PC one cycle later.
- Load x5 issued, then add x6,x5,x1 presented: stall while busy[5]; i_wb_valid with rd=5 in cycle N → add accepted in cycle N, and o_iss_valid shows pc_add in N+1.
- MAX_OUTSTANDING=2: three loads to x1,x2,x3 with no writeback → third stalls; one writeback → third accepted that cycle.
- Load x7 held with i_iss_ready=0 and i_flush=1 → o_iss_valid=0 next cycle, busy[7]=0, count=0; a following use of x7 is not stalled.
- Illegal instruction at 0x100 → o_trap=1, o_trap_pc=0x100, stall held for 5 cycles; i_trap_ack → RUN next cycle, stall released.
- Writeback with count=0 → o_err=1 and stays set; i_reset=1 → all outputs return to their reset values.
